// File: rtl/mem_access_unit.sv
// Memory access unit: takes one decoded load/store from the address FU,
// issues a single request to the data memory port, aligns/extends load data
// and holds the result until the CDB grants it.
module mem_access_unit #(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic             in_is_store,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             squash,
  output logic             stall_out,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  output logic             mem_req_is_store,
  output logic [XLEN-1:0]  mem_req_wdata,
  output logic [3:0]       mem_req_wmask,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_data,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_is_store,
  output logic             out_exc,
  input  logic             out_ack
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [3:0]         r_wmask;
  logic               r_is_store;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [TAG_W-1:0]   r_tag;
  logic               r_exc;
  logic [XLEN-1:0]    r_out_data;

  logic               w_accept;
  logic               w_misaligned;
  logic [XLEN-1:0]    w_lane_wdata;
  logic [3:0]         w_lane_wmask;
  logic               w_req_fire;
  logic [XLEN-1:0]    w_resp_shift;
  logic [XLEN-1:0]    w_load_data;

  assign w_accept   = (r_state == ST_IDLE) && in_valid && !squash;
  assign w_req_fire = mem_req_valid && mem_req_ready;

  // Detect misaligned halves/words and the reserved size encoding
  always_comb begin
    w_misaligned = 1'b0;
    case (in_size)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = in_addr[0];
      SZ_WORD: w_misaligned = |in_addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Steer store data and byte enables onto the lanes selected by addr[1:0]
  always_comb begin
    w_lane_wdata = '0;
    w_lane_wmask = 4'b0000;
    case (in_size)
      SZ_BYTE: begin
        w_lane_wdata = {4{in_wdata[7:0]}};
        w_lane_wmask = 4'b0001 << in_addr[1:0];
      end
      SZ_HALF: begin
        w_lane_wdata = {2{in_wdata[15:0]}};
        w_lane_wmask = 4'b0011 << in_addr[1:0];
      end
      SZ_WORD: begin
        w_lane_wdata = in_wdata;
        w_lane_wmask = 4'b1111;
      end
      default: begin
        w_lane_wdata = '0;
        w_lane_wmask = 4'b0000;
      end
    endcase
  end

  // Right-justify the addressed bytes of the response and extend them
  always_comb begin
    w_resp_shift = mem_resp_data >> {r_addr[1:0], 3'b000};
    w_load_data  = w_resp_shift;
    case (r_size)
      SZ_BYTE: w_load_data = r_unsigned ? {{(XLEN-8){1'b0}}, w_resp_shift[7:0]}
                                        : {{(XLEN-8){w_resp_shift[7]}}, w_resp_shift[7:0]};
      SZ_HALF: w_load_data = r_unsigned ? {{(XLEN-16){1'b0}}, w_resp_shift[15:0]}
                                        : {{(XLEN-16){w_resp_shift[15]}}, w_resp_shift[15:0]};
      default: w_load_data = w_resp_shift;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    w_next        = r_state;
    stall_out     = (r_state != ST_IDLE);
    mem_req_valid = (r_state == ST_REQ) && !squash;
    out_valid     = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_misaligned ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (squash) begin
          w_next = ST_IDLE;
        end else if (w_req_fire) begin
          w_next = r_is_store ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (squash) begin
          w_next = mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ack || squash) begin
          w_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the accepted op and capture the aligned load result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= 4'b0000;
      r_is_store <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_tag      <= '0;
      r_exc      <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= in_addr;
        r_wdata    <= in_is_store ? w_lane_wdata : '0;
        r_wmask    <= (in_is_store && !w_misaligned) ? w_lane_wmask : 4'b0000;
        r_is_store <= in_is_store;
        r_size     <= in_size;
        r_unsigned <= in_unsigned;
        r_tag      <= in_tag;
        r_exc      <= w_misaligned;
        r_out_data <= '0;
      end
      if ((r_state == ST_WAIT) && mem_resp_valid && !squash) begin
        r_out_data <= w_load_data;
      end
    end
  end

  assign mem_req_addr     = {r_addr[XLEN-1:2], 2'b00};
  assign mem_req_is_store = r_is_store;
  assign mem_req_wdata    = r_wdata;
  assign mem_req_wmask    = r_wmask;
  assign out_data         = r_out_data;
  assign out_tag          = r_tag;
  assign out_is_store     = r_is_store;
  assign out_exc          = r_exc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an expected-result queue.
module tb_mem_access_unit;

  localparam int unsigned TAG_W = 6;
  localparam int unsigned XLEN  = 32;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_wdata;
  logic             in_is_store;
  logic [1:0]       in_size;
  logic             in_unsigned;
  logic [TAG_W-1:0] in_tag;
  logic             squash;
  logic             stall_out;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [XLEN-1:0]  mem_req_addr;
  logic             mem_req_is_store;
  logic [XLEN-1:0]  mem_req_wdata;
  logic [3:0]       mem_req_wmask;
  logic             mem_resp_valid;
  logic [XLEN-1:0]  mem_resp_data;
  logic             out_valid;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_is_store;
  logic             out_exc;
  logic             out_ack;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             is_store;
    logic             exc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mem_access_unit #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_addr         (in_addr),
    .in_wdata        (in_wdata),
    .in_is_store     (in_is_store),
    .in_size         (in_size),
    .in_unsigned     (in_unsigned),
    .in_tag          (in_tag),
    .squash          (squash),
    .stall_out       (stall_out),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_is_store(mem_req_is_store),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wmask   (mem_req_wmask),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_tag         (out_tag),
    .out_is_store    (out_is_store),
    .out_exc         (out_exc),
    .out_ack         (out_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle past the edge before sampling
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept cycle and record its expected result
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic st,
                       input logic [1:0] sz, input logic uns, input logic [TAG_W-1:0] tag,
                       input logic push, input logic [31:0] exp_data, input logic exp_exc);
    exp_t e;
    in_addr     = addr;
    in_wdata    = wdata;
    in_is_store = st;
    in_size     = sz;
    in_unsigned = uns;
    in_tag      = tag;
    in_valid    = 1'b1;
    if (push) begin
      e.data     = exp_data;
      e.tag      = tag;
      e.is_store = st;
      e.exc      = exp_exc;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Pop the oldest expected result and compare the presented one
  task automatic compare_out(input string name);
    exp_t e;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, out_data, e.data);
      chk({name, "_tag"}, 32'(out_tag), 32'(e.tag));
      chk({name, "_is_store"}, 32'(out_is_store), 32'(e.is_store));
      chk({name, "_exc"}, 32'(out_exc), 32'(e.exc));
    end
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("ack_idle_stall", 32'(stall_out), 32'd0);
  endtask

  // Load with immediate memory ready and response one cycle later
  task automatic do_load(input string name, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [TAG_W-1:0] tag,
                         input logic [31:0] resp, input logic [31:0] exp_data);
    mem_req_ready = 1'b1;
    issue(addr, 32'h0, 1'b0, sz, uns, tag, 1'b1, exp_data, 1'b0);
    chk({name, "_req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({name, "_req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    chk({name, "_wmask"}, 32'(mem_req_wmask), 32'd0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = resp;
    chk({name, "_wait_no_out"}, 32'(out_valid), 32'd0);
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    compare_out(name);
    ack();
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_addr        = '0;
    in_wdata       = '0;
    in_is_store    = 1'b0;
    in_size        = 2'd0;
    in_unsigned    = 1'b0;
    in_tag         = '0;
    squash         = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_ack        = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exc", 32'(out_exc), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    step();

    // Aligned LW with minimum latency
    issue(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 6'd5, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("lw_stall_t1", 32'(stall_out), 32'd1);
    chk("lw_req_valid", 32'(mem_req_valid), 32'd1);
    chk("lw_req_addr", mem_req_addr, 32'h1000);
    chk("lw_wmask", 32'(mem_req_wmask), 32'd0);
    chk("lw_req_is_store", 32'(mem_req_is_store), 32'd0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    chk("lw_t2_no_out", 32'(out_valid), 32'd0);
    chk("lw_stall_t2", 32'(stall_out), 32'd1);
    step();
    mem_resp_valid = 1'b0;
    chk("lw_stall_t3", 32'(stall_out), 32'd1);
    compare_out("lw");
    ack();

    // Sub-word loads with sign/zero extension
    do_load("lb",  32'h1003, 2'd0, 1'b0, 6'd6, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 32'h1003, 2'd0, 1'b1, 6'd7, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh",  32'h1002, 2'd1, 1'b0, 6'd8, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lhu", 32'h1000, 2'd1, 1'b1, 6'd9, 32'h1234_F00D, 32'h0000_F00D);
    do_load("lb1", 32'h1001, 2'd0, 1'b0, 6'd10, 32'h1234_5678, 32'h0000_0056);

    // SB with memory stalling for three cycles
    mem_req_ready = 1'b0;
    issue(32'h2001, 32'h0000_00AB, 1'b1, 2'd0, 1'b0, 6'd11, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req_valid", 32'(mem_req_valid), 32'd1);
      chk("sb_req_addr", mem_req_addr, 32'h2000);
      chk("sb_wmask", 32'(mem_req_wmask), 32'b0010);
      chk("sb_wdata", mem_req_wdata, 32'hABAB_ABAB);
      chk("sb_is_store", 32'(mem_req_is_store), 32'd1);
      chk("sb_no_out", 32'(out_valid), 32'd0);
      step();
    end
    mem_req_ready = 1'b1;
    chk("sb_req_held", mem_req_wdata, 32'hABAB_ABAB);
    step();
    compare_out("sb");
    ack();

    // SH at upper half and SW
    issue(32'h2002, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 6'd12, 1'b1, 32'h0, 1'b0);
    chk("sh_wmask", 32'(mem_req_wmask), 32'b1100);
    chk("sh_wdata", mem_req_wdata, 32'hBEEF_BEEF);
    step();
    compare_out("sh");
    ack();
    issue(32'h2004, 32'h1357_9BDF, 1'b1, 2'd2, 1'b0, 6'd13, 1'b1, 32'h0, 1'b0);
    chk("sw_wmask", 32'(mem_req_wmask), 32'b1111);
    chk("sw_wdata", mem_req_wdata, 32'h1357_9BDF);
    chk("sw_addr", mem_req_addr, 32'h2004);
    step();
    compare_out("sw");
    ack();

    // Misaligned / reserved-size accesses take the exception path
    issue(32'h1002, 32'h0, 1'b0, 2'd2, 1'b0, 6'd14, 1'b1, 32'h0, 1'b1);
    chk("lw_mis_no_req", 32'(mem_req_valid), 32'd0);
    compare_out("lw_mis");
    ack();
    issue(32'h1001, 32'h55, 1'b1, 2'd1, 1'b0, 6'd15, 1'b1, 32'h0, 1'b1);
    chk("sh_mis_no_req", 32'(mem_req_valid), 32'd0);
    compare_out("sh_mis");
    ack();
    issue(32'h1000, 32'h0, 1'b0, 2'd3, 1'b0, 6'd16, 1'b1, 32'h0, 1'b1);
    chk("rsv_no_req", 32'(mem_req_valid), 32'd0);
    compare_out("rsv");
    ack();

    // Squash in WAIT, response arrives later and is drained
    issue(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 6'd17, 1'b0, 32'h0, 1'b0);
    step();
    squash = 1'b1;
    step();
    squash = 1'b0;
    chk("drain_stall0", 32'(stall_out), 32'd1);
    chk("drain_no_out0", 32'(out_valid), 32'd0);
    step();
    chk("drain_stall1", 32'(stall_out), 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h7777_7777;
    step();
    mem_resp_valid = 1'b0;
    chk("drain_idle", 32'(stall_out), 32'd0);
    chk("drain_no_out", 32'(out_valid), 32'd0);
    do_load("post_drain", 32'h1000, 2'd2, 1'b0, 6'd18, 32'h1122_3344, 32'h1122_3344);

    // Squash in REQ withdraws the request
    mem_req_ready = 1'b0;
    issue(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 6'd19, 1'b0, 32'h0, 1'b0);
    squash = 1'b1;
    #1;
    chk("sq_req_gated", 32'(mem_req_valid), 32'd0);
    step();
    squash = 1'b0;
    mem_req_ready = 1'b1;
    chk("sq_req_idle", 32'(stall_out), 32'd0);

    // Ack held off: result stable, new input ignored; accepted the cycle after ack
    issue(32'h1000, 32'h0, 1'b0, 2'd2, 1'b0, 6'd3, 1'b1, 32'hCAFE_F00D, 1'b0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    step();
    mem_resp_valid = 1'b0;
    in_addr     = 32'h3000;
    in_is_store = 1'b0;
    in_size     = 2'd2;
    in_unsigned = 1'b0;
    in_tag      = 6'd12;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'hCAFE_F00D);
      chk("hold_tag", 32'(out_tag), 32'd3);
      chk("hold_stall", 32'(stall_out), 32'd1);
      step();
    end
    compare_out("hold");
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    chk("ackcyc_not_taken", 32'(stall_out), 32'd0);
    sb.push_back('{data: 32'h0BAD_C0DE, tag: 6'd12, is_store: 1'b0, exc: 1'b0});
    step();
    in_valid = 1'b0;
    chk("after_ack_accept", 32'(stall_out), 32'd1);
    chk("after_ack_req", 32'(mem_req_valid), 32'd1);
    chk("after_ack_addr", mem_req_addr, 32'h3000);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BAD_C0DE;
    step();
    mem_resp_valid = 1'b0;
    compare_out("after_ack");
    ack();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
